// File: rtl/datapath_legv8_seq.sv
// datapath_legv8_seq: multi-cycle LEGv8 datapath (regfile, ALU, handshaked load/store port).
// Define DATAPATH_FLAGREG_EN to make status a SetFlags-gated register; otherwise it tracks every EXEC.
module datapath_legv8_seq #(
    parameter int WIDTH = 64,
    parameter int SEL_W = 5,
    parameter int CW_W  = 3*SEL_W+10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CW_W-1:0]  cw,
    input  logic [WIDTH-1:0] constant,
    input  logic             cw_valid,
    output logic             cw_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic [3:0]       status
);
    typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;
    localparam logic [SEL_W-1:0] XZR = '1;
    state_t state, state_n;
    logic [WIDTH-1:0] rf [2**SEL_W];
    logic [WIDTH-1:0] a_q, b_q, rb_q, alu_q, rdata_q, alu, aa, bb, wb, ra, rb;
    logic [WIDTH:0] sum;
    logic [SEL_W-1:0] sa, sb, da_q;
    logic [4:0] fs_q;
    logic [3:0] flags;
    logic rw_q, mw_q, mr_q, load, add, accept, wr;
`ifdef DATAPATH_FLAGREG_EN
    logic sf_q;
`else
    logic unused_sf;
    assign unused_sf = cw[0];
`endif

    assign sa        = cw[CW_W-1 -: SEL_W];
    assign sb        = cw[CW_W-1-SEL_W -: SEL_W];
    assign ra        = (sa == XZR) ? '0 : rf[sa];
    assign rb        = (sb == XZR) ? '0 : rf[sb];
    assign accept    = cw_valid && cw_ready;
    // MemRead together with MemWrite behaves as a store
    assign load      = mr_q && !mw_q;
    assign wb        = load ? rdata_q : alu_q;
    assign wr        = (state == WB) && rw_q && (da_q != XZR);
    assign mem_addr  = alu_q;
    assign mem_wdata = rb_q;

    always_comb begin
        state_n  = state;
        cw_ready = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        case (state)
            IDLE: begin
                cw_ready = 1'b1;
                state_n  = cw_valid ? EXEC : IDLE;
            end
            EXEC: state_n = (mr_q || mw_q) ? MEM : WB;
            MEM: begin
                mem_req = 1'b1;
                mem_we  = mw_q;
                state_n = mem_ack ? WB : MEM;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        aa    = fs_q[1] ? ~a_q : a_q;
        bb    = fs_q[0] ? ~b_q : b_q;
        sum   = {1'b0, aa} + {1'b0, bb} + {{WIDTH{1'b0}}, fs_q[0]};
        add   = fs_q[4:2] == 3'd2;
        alu   = fs_q[4:2] == 3'd0 ? aa & bb :
                fs_q[4:2] == 3'd1 ? aa | bb :
                fs_q[4:2] == 3'd2 ? sum[WIDTH-1:0] :
                fs_q[4:2] == 3'd3 ? aa ^ bb :
                fs_q[4:2] == 3'd4 ? aa << bb[5:0] :
                fs_q[4:2] == 3'd5 ? aa >> bb[5:0] : '0;
        flags = {add && (aa[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != aa[WIDTH-1]),
                 add && sum[WIDTH], alu[WIDTH-1], alu == '0};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2**SEL_W; i++) rf[i] <= '0;
        end else if (wr) begin
            rf[da_q] <= wb;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            rb_q    <= '0;
            alu_q   <= '0;
            rdata_q <= '0;
            da_q    <= '0;
            {rw_q, mw_q, mr_q, fs_q} <= '0;
`ifdef DATAPATH_FLAGREG_EN
            sf_q    <= 1'b0;
`endif
            result  <= '0;
            done    <= 1'b0;
            status  <= '0;
        end else begin
            if (accept) begin
                a_q  <= ra;
                rb_q <= rb;
                b_q  <= cw[1] ? constant : rb;
                da_q <= cw[CW_W-1-2*SEL_W -: SEL_W];
                {rw_q, mw_q, mr_q, fs_q} <= cw[9:2];
`ifdef DATAPATH_FLAGREG_EN
                sf_q <= cw[0];
`endif
            end
            if (state == EXEC) begin
                alu_q <= alu;
`ifdef DATAPATH_FLAGREG_EN
                if (sf_q) status <= flags;
`else
                status <= flags;
`endif
            end
            if (state == MEM && mem_ack && load) rdata_q <= mem_rdata;
            done <= state == WB;
            if (wr) result <= wb;
        end
    end
endmodule

// File: tb/tb_datapath_legv8_seq.sv
// tb_datapath_legv8_seq: directed checks of datapath_legv8_seq (ALU ops, flags, memory waits, XZR, reset abort).
module tb_datapath_legv8_seq;
    localparam logic [4:0] F_ADD = 5'b01000;
    localparam logic [4:0] F_SUB = 5'b01001;
    localparam logic [4:0] F_LSL = 5'b10000;
    localparam logic [4:0] F_LSR = 5'b10100;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [24:0] cw = '0;
    logic [63:0] constant = '0;
    logic [63:0] mem_rdata = '0;
    logic        cw_valid = 1'b0;
    logic        mem_ack = 1'b0;
    logic        cw_ready, mem_req, mem_we, done;
    logic [63:0] mem_addr, mem_wdata, result;
    logic [3:0]  status;
    int          checks = 0;
    int          errors = 0;
    int          lat, reqs;
    logic [63:0] addr0, wdata0;
    logic        we0, seen;

    datapath_legv8_seq dut (
        .clock(clock), .reset(reset), .cw(cw), .constant(constant), .cw_valid(cw_valid),
        .cw_ready(cw_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .result(result),
        .done(done), .status(status)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [24:0] mk(input logic [4:0] sa, input logic [4:0] sb, input logic [4:0] da,
                                       input logic rw, input logic mw, input logic mr,
                                       input logic [4:0] fs, input logic bs, input logic sf);
        return {sa, sb, da, rw, mw, mr, fs, bs, sf};
    endfunction

    // Issues one control word, answers the memory port after ack_n request cycles, and records
    // the retire latency in cycles after the accepting edge (0 if done never arrives).
    task automatic run(input logic [24:0] c, input logic [63:0] k, input int ack_n, input logic [63:0] rd);
        @(negedge clock);
        chk("ready_before_issue", 64'(cw_ready), 64'd1);
        cw = c;
        constant = k;
        cw_valid = 1'b1;
        @(posedge clock);
        #1 cw_valid = 1'b0;
        lat = 0;
        reqs = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            mem_ack = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
            if (mem_req) begin
                if (reqs == 0) begin
                    addr0 = mem_addr;
                    wdata0 = mem_wdata;
                    we0 = mem_we;
                end
                if (reqs == ack_n) begin
                    mem_ack = 1'b1;
                    mem_rdata = rd;
                end
                reqs++;
            end
        end
    endtask

    task automatic read_reg(input logic [4:0] r);
        run(mk(r, 5'd0, 5'd30, 1'b1, 1'b0, 1'b0, F_ADD, 1'b1, 1'b0), 64'd0, 0, 64'd0);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_ready", 64'(cw_ready), 64'd1);
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_status", 64'(status), 64'd0);
        run(mk(5'd31, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, F_ADD, 1'b1, 1'b0), 64'd5, 0, 64'd0);
        chk("t1_latency", 64'(lat), 64'd3);
        chk("t1_result", result, 64'd5);
        chk("t1_status", 64'(status), 64'd0);
        @(negedge clock);
        chk("t1_done_pulse", 64'(done), 64'd0);
        run(mk(5'd31, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, F_ADD, 1'b1, 1'b0), 64'd5, 0, 64'd0);
        run(mk(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, F_SUB, 1'b0, 1'b1), 64'd0, 0, 64'd0);
        chk("t2_latency", 64'(lat), 64'd3);
        chk("t2_result", result, 64'd0);
        chk("t2_status", 64'(status), 64'b0101);
        run(mk(5'd31, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, F_ADD, 1'b1, 1'b0), 64'h10, 0, 64'd0);
        run(mk(5'd1, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, F_ADD, 1'b1, 1'b0), 64'd8, 3, 64'hDEAD);
        chk("t3_addr", addr0, 64'h18);
        chk("t3_we", 64'(we0), 64'd0);
        chk("t3_req_cycles", 64'(reqs), 64'd4);
        chk("t3_latency", 64'(lat), 64'd7);
        chk("t3_result", result, 64'hDEAD);
        run(mk(5'd1, 5'd2, 5'd31, 1'b0, 1'b1, 1'b0, F_ADD, 1'b1, 1'b0), 64'h20, 0, 64'd0);
        chk("st_addr", addr0, 64'h30);
        chk("st_wdata", wdata0, 64'd5);
        chk("st_we", 64'(we0), 64'd1);
        chk("st_latency", 64'(lat), 64'd4);
        chk("st_result_hold", result, 64'hDEAD);
        read_reg(5'd4);
        chk("t3_reg", result, 64'hDEAD);
        run(mk(5'd31, 5'd0, 5'd31, 1'b1, 1'b0, 1'b0, F_ADD, 1'b1, 1'b0), 64'd7, 0, 64'd0);
        chk("t4_result_hold", result, 64'hDEAD);
        read_reg(5'd31);
        chk("t4_xzr_read", result, 64'd0);
        run(mk(5'd1, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, F_LSL, 1'b1, 1'b0), 64'd4, 0, 64'd0);
        chk("lsl_result", result, 64'h100);
        run(mk(5'd31, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, F_ADD, 1'b1, 1'b0), 64'h7FFF_FFFF_FFFF_FFFF, 0, 64'd0);
        run(mk(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, F_ADD, 1'b1, 1'b1), 64'd1, 0, 64'd0);
        chk("t5_result", result, 64'h8000_0000_0000_0000);
        chk("t5_status", 64'(status), 64'b1010);
        run(mk(5'd6, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0, F_LSR, 1'b1, 1'b0), 64'd63, 0, 64'd0);
        chk("lsr_result", result, 64'd1);
`ifdef DATAPATH_FLAGREG_EN
        chk("t5_status_hold", 64'(status), 64'b1010);
`else
        chk("t5_status_track", 64'(status), 64'b0000);
`endif
        @(negedge clock);
        cw = mk(5'd1, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, F_ADD, 1'b1, 1'b0);
        constant = 64'd0;
        cw_valid = 1'b1;
        @(posedge clock);
        #1 cw_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clock);
            seen = mem_req;
        end
        chk("t6_req_seen", 64'(seen), 64'd1);
        reset = 1'b1;
        #1;
        chk("t6_req_drop", 64'(mem_req), 64'd0);
        chk("t6_ready", 64'(cw_ready), 64'd1);
        @(negedge clock);
        reset = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 64'hBEEF;
        @(negedge clock);
        mem_ack = 1'b0;
        chk("t6_idle_after_ack", 64'(cw_ready), 64'd1);
        chk("t6_no_done", 64'(done), 64'd0);
        chk("t6_result_cleared", result, 64'd0);
        read_reg(5'd8);
        chk("t6_no_write", result, 64'd0);
        chk("t6_latency", 64'(lat), 64'd3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
